z88_ps2_kbd: RTL and testbench
==============================

// Module: z88_ps2_kbd
// PURPOSE
//   PS/2 keyboard front-end that produces the 64-bit Z88 key matrix driving the top-level kb_matrix input.
//   - Receives PS/2 set-2 frames and tracks make/break/extended prefixes.
//   - Translates scancodes to Z88 row/column positions and holds pressed/released state per key.
//   - Runs entirely on clk; ps2_clk/ps2_data are asynchronous and are synchronised internally.
// PARAMETERS
//   FILTER_LEN   8       consecutive equal samples required before ps2_clk level change is accepted
//   TIMEOUT_CYC  100000  clk cycles without a ps2_clk fall before a partial frame is aborted
// PORTS
//   rst        in   1   asynchronous reset, active-high
//   clk        in   1   system clock
//   ps2_clk    in   1   PS/2 clock from keyboard (async, open-drain, idle high)
//   ps2_data   in   1   PS/2 data from keyboard (async, idle high)
//   kb_matrix  out  64  key state, bit = row*8+col, 0 = pressed (active-low, as Z88 KBD lines)
//   scan_vld   out  1   one-cycle pulse: a byte was received with good parity and stop bit
//   scan_code  out  8   last good byte; valid while scan_vld=1, held afterwards
//   scan_err   out  1   one-cycle pulse: parity/stop error (or timeout, see CONFIGURATION)
// BEHAVIOUR
//   Reset values: kb_matrix=64'hFFFF_FFFF_FFFF_FFFF, scan_vld=0, scan_code=8'h00, scan_err=0.
//   Reset clears the receiver FSM, prefix flags, pause counter and filter.
//   Reset mid-frame discards the partial byte.
//   Input conditioning:
//   - 2-FF synchroniser on both inputs.
//   - ps2_clk passes through FILTER_LEN glitch filter.
//   - A filtered 1->0 transition is a "fall".
//   - Data is sampled on the synchronised ps2_data in the fall cycle.
//   Receiver FSM (advances on fall only):
//   - IDLE: data=0 -> DATA (bit cnt=0). data=1 -> stay in IDLE, no error.
//   - DATA: shift right, LSB first; after 8th bit -> PARITY.
//   - PARITY: store bit -> STOP.
//   - STOP: if data=1 and odd parity over 9 bits is correct, pulse scan_vld and load scan_code
//     1 cycle after the fall; else pulse scan_err. Both cases -> IDLE.
//   Decoder (acts on scan_vld; kb_matrix updates the cycle after scan_vld):
//   - E0: set ext. F0: set brk. No matrix change.
//   - E1: Pause prefix; ignore the next 7 bytes (3-bit counter), then resume normal decoding.
//   - AA, FA, EE: ignored; prefix flags unchanged.
//   - 00 or FF (overrun/error): kb_matrix <= all ones, clear flags.
//   - Other byte: keymap lookup on {ext,code} -> {hit,row,col}.
//     hit=1 -> bit[row*8+col] <= brk. hit=0 -> no change. Clear ext and brk in both cases.
//   - scan_err clears ext and brk; kb_matrix is unchanged.
//   Simultaneous events: scan_err and scan_vld are never asserted together.
//   - A fall during the decode cycle is accepted normally: decode takes 1 cycle, so no backpressure is needed.
//   Repeated make of an already pressed key is idempotent; typematic repeats cause no change.
// CONFIGURATION
//   PS2_TIMEOUT_EN defined:
//   - In any non-IDLE receiver state, a 17-bit counter counts cycles since the last fall.
//   - When the counter reaches TIMEOUT_CYC: FSM -> IDLE, pulse scan_err, clear ext and brk.
//   - The counter clears on every fall and in IDLE.
//   PS2_TIMEOUT_EN undefined:
//   - No counter. The FSM waits indefinitely for the next fall; a partial frame is resynchronised only by reset.
// STRUCTURE
//   Package z88_kbd_pkg:
//   - PS2 prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA, PS2_ACK=8'hFA,
//     PS2_ECHO=8'hEE, PS2_OVR0=8'h00, PS2_OVR1=8'hFF.
//   - Keymap entry struct {hit, row[2:0], col[2:0]}.
//   Sub-module z88_ps2_keymap:
//   - Combinational case table: 9-bit {ext,code} in -> keymap entry out.
//   - Holds all 64 Z88 keys, e.g. 0x1C 'A' -> row 4 col 5 (bit 37); 0x29 SPACE -> row 6 col 6 (bit 54);
//     E0 75 UP -> row 6 col 3 (bit 51).
//   - Unmapped codes -> hit=0.
// TESTING
//   1. Frame 0x1C with odd parity 0, stop 1 -> scan_vld pulse, scan_code=8'h1C; next cycle kb_matrix[37]=0, all other bits 1.
//   2. F0 1C after test 1 -> kb_matrix[37]=1; the F0 byte alone changes nothing; matrix back to all ones.
//   3. E0 75, then E0 F0 75 -> bit 51 goes 0 then 1. Plain 75 (hit=0 in map) leaves the matrix unchanged.
//   4. 0x1C frame with parity bit flipped -> scan_err pulse, no scan_vld, kb_matrix unchanged.
//      A following good F0 1C works normally.
//   5. Press 0x1C and 0x29, then send FF -> kb_matrix=all ones.
//      E1 14 77 E1 F0 14 F0 77 -> no change; a subsequent 0x1C presses bit 37.
//   6. PS2_TIMEOUT_EN: stop ps2_clk after 4 data bits -> scan_err exactly TIMEOUT_CYC cycles after the last fall;
//      the next full 0x29 frame decodes to bit 54=0. A reset asserted mid-frame returns all outputs to reset values.

Source files
------------

// File: rtl/z88_kbd_pkg.sv
// rtl/z88_kbd_pkg.sv - shared constants, keymap entry type and receiver states for the Z88 PS/2 keyboard front-end
package z88_kbd_pkg;

  // PS/2 set-2 prefix and special bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_OVR0  = 8'h00;
  localparam logic [7:0] PS2_OVR1  = 8'hFF;

  // Bytes to swallow after a Pause prefix (E1 14 77 E1 F0 14 F0 77)
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } keymap_entry_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Build a mapped keymap entry from a row/column pair
  function automatic keymap_entry_t km(input int unsigned r, input int unsigned c);
    keymap_entry_t e;
    e.hit = 1'b1;
    e.row = r[2:0];
    e.col = c[2:0];
    return e;
  endfunction

endpackage

// File: rtl/z88_ps2_keymap.sv
// rtl/z88_ps2_keymap.sv - combinational {ext,scancode} to Z88 matrix row/column table
module z88_ps2_keymap
  import z88_kbd_pkg::*;
(
  input  logic [8:0]    key_i,
  output keymap_entry_t entry_o
);

  // One entry per Z88 key; bit 8 of key_i is the E0 extended flag
  always_comb begin
    entry_o = '0;
    case (key_i)
      // row 0: digits 1-8
      9'h016: entry_o = km(0, 0);
      9'h01E: entry_o = km(0, 1);
      9'h026: entry_o = km(0, 2);
      9'h025: entry_o = km(0, 3);
      9'h02E: entry_o = km(0, 4);
      9'h036: entry_o = km(0, 5);
      9'h03D: entry_o = km(0, 6);
      9'h03E: entry_o = km(0, 7);
      // row 1: 9 0 - = \ DEL Q W
      9'h046: entry_o = km(1, 0);
      9'h045: entry_o = km(1, 1);
      9'h04E: entry_o = km(1, 2);
      9'h055: entry_o = km(1, 3);
      9'h05D: entry_o = km(1, 4);
      9'h066: entry_o = km(1, 5);
      9'h015: entry_o = km(1, 6);
      9'h01D: entry_o = km(1, 7);
      // row 2: E R T Y U I O P
      9'h024: entry_o = km(2, 0);
      9'h02D: entry_o = km(2, 1);
      9'h02C: entry_o = km(2, 2);
      9'h035: entry_o = km(2, 3);
      9'h03C: entry_o = km(2, 4);
      9'h043: entry_o = km(2, 5);
      9'h044: entry_o = km(2, 6);
      9'h04D: entry_o = km(2, 7);
      // row 3: [ ] TAB ESC ENTER ; ' ,
      9'h054: entry_o = km(3, 0);
      9'h05B: entry_o = km(3, 1);
      9'h00D: entry_o = km(3, 2);
      9'h076: entry_o = km(3, 3);
      9'h05A: entry_o = km(3, 4);
      9'h04C: entry_o = km(3, 5);
      9'h052: entry_o = km(3, 6);
      9'h041: entry_o = km(3, 7);
      // row 4: Z X C V S A D F
      9'h01A: entry_o = km(4, 0);
      9'h022: entry_o = km(4, 1);
      9'h021: entry_o = km(4, 2);
      9'h02A: entry_o = km(4, 3);
      9'h01B: entry_o = km(4, 4);
      9'h01C: entry_o = km(4, 5);
      9'h023: entry_o = km(4, 6);
      9'h02B: entry_o = km(4, 7);
      // row 5: G H J K L B N M
      9'h034: entry_o = km(5, 0);
      9'h033: entry_o = km(5, 1);
      9'h03B: entry_o = km(5, 2);
      9'h042: entry_o = km(5, 3);
      9'h04B: entry_o = km(5, 4);
      9'h032: entry_o = km(5, 5);
      9'h031: entry_o = km(5, 6);
      9'h03A: entry_o = km(5, 7);
      // row 6: . / pound(`) UP LSHIFT RSHIFT SPACE CAPS
      9'h049: entry_o = km(6, 0);
      9'h04A: entry_o = km(6, 1);
      9'h00E: entry_o = km(6, 2);
      9'h175: entry_o = km(6, 3);
      9'h012: entry_o = km(6, 4);
      9'h059: entry_o = km(6, 5);
      9'h029: entry_o = km(6, 6);
      9'h058: entry_o = km(6, 7);
      // row 7: LEFT RIGHT DOWN HELP(F1) INDEX(F2) MENU(F3) DIAMOND(LCTRL) SQUARE(LALT)
      9'h16B: entry_o = km(7, 0);
      9'h174: entry_o = km(7, 1);
      9'h172: entry_o = km(7, 2);
      9'h005: entry_o = km(7, 3);
      9'h006: entry_o = km(7, 4);
      9'h004: entry_o = km(7, 5);
      9'h014: entry_o = km(7, 6);
      9'h011: entry_o = km(7, 7);
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/z88_ps2_kbd.sv
// rtl/z88_ps2_kbd.sv - PS/2 set-2 receiver and decoder producing the 64-bit Z88 key matrix (option: PS2_TIMEOUT_EN)
module z88_ps2_kbd
  import z88_kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [63:0] kb_matrix,
  output logic        scan_vld,
  output logic [7:0]  scan_code,
  output logic        scan_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);

  // The timeout counter is 17 bits wide; refuse values it cannot reach
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 131071) begin : g_to_range
    $error("TIMEOUT_CYC out of range for 17-bit counter");
  end

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            fall;

  rx_state_t       state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic [7:0]      code_q, code_d;

  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [2:0]      pause_q, pause_d;
  logic [63:0]     kb_q, kb_d;
  keymap_entry_t   entry;

`ifdef PS2_TIMEOUT_EN
  localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYC - 1);
  logic [16:0]     to_q, to_d;
`endif

  // Two-flop synchronisers; lines idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: accept a new ps2_clk level after FILTER_LEN differing samples; flag falls
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == F_LAST) begin
        filt_d = clk_s2_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Receiver next state: frame is start, 8 data LSB first, odd parity, stop
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = RX_DATA;
            bitcnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_s2_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (dat_s2_q && (^{shift_q, par_q})) begin
            vld_d  = 1'b1;
            code_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    to_d = to_q + 17'd1;
    if (state_q == RX_IDLE || fall) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      to_d    = '0;
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
`endif
  end

  z88_ps2_keymap u_keymap (
    .key_i   ({ext_q, code_q}),
    .entry_o (entry)
  );

  // Decoder: prefix tracking and matrix update, one cycle after each received byte
  always_comb begin
    kb_d    = kb_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    pause_d = pause_q;
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (vld_q) begin
      if (pause_q != 3'd0) begin
        pause_d = pause_q - 3'd1;
      end else begin
        case (code_q)
          PS2_EXT:   ext_d   = 1'b1;
          PS2_BRK:   brk_d   = 1'b1;
          PS2_PAUSE: pause_d = PAUSE_SKIP;
          PS2_BAT, PS2_ACK, PS2_ECHO: ;
          PS2_OVR0, PS2_OVR1: begin
            kb_d  = '1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            if (entry.hit) kb_d[{entry.row, entry.col}] = brk_q;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  // State registers for filter, receiver and decoder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= RX_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      pause_q  <= '0;
      kb_q     <= '1;
`ifdef PS2_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      code_q   <= code_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      pause_q  <= pause_d;
      kb_q     <= kb_d;
`ifdef PS2_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign kb_matrix = kb_q;
  assign scan_vld  = vld_q;
  assign scan_code = code_q;
  assign scan_err  = err_q;

endmodule

// File: tb/tb_z88_ps2_kbd.sv
// tb/tb_z88_ps2_kbd.sv - self-checking bench for z88_ps2_kbd (timeout section under PS2_TIMEOUT_EN)
module tb_z88_ps2_kbd;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 16;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        rst, clk, ps2_clk, ps2_data;
  logic [63:0] kb_matrix;
  logic        scan_vld, scan_err;
  logic [7:0]  scan_code;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [7:0]  code;
    logic        bad;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] code;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  z88_ps2_kbd #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .rst       (rst),
    .clk       (clk),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .kb_matrix (kb_matrix),
    .scan_vld  (scan_vld),
    .scan_code (scan_code),
    .scan_err  (scan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] key(input int b);
    return ~(64'd1 << b);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void add(input logic [7:0] c, input logic b, input logic [63:0] e);
    vec_t v;
    v.code = c;
    v.bad  = b;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] c, input logic bad);
    return {1'b1, (~^c) ^ bad, c, 1'b0};
  endfunction

  function automatic void expect_byte(input logic [7:0] c, input logic err);
    sb_t s;
    s.err  = err;
    s.code = c;
    sbq.push_back(s);
  endfunction

  // Scoreboard: every received byte or error must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && (scan_vld || scan_err)) begin
      if (sbq.size() == 0) begin
        check("unexpected_scan_event", {62'd0, scan_vld, scan_err}, 64'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("scan_err_flag", {63'd0, scan_err}, {63'd0, e.err});
        check("scan_vld_flag", {63'd0, scan_vld}, {63'd0, ~e.err});
        if (!e.err) check("scan_code", {56'd0, scan_code}, {56'd0, e.code});
      end
    end
  end

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] c, input logic bad);
    expect_byte(c, bad);
    send_bits(frame(c, bad), 11);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_kb_matrix"}, kb_matrix, ALL);
    check({tag, "_scan_vld"}, {63'd0, scan_vld}, 64'd0);
    check({tag, "_scan_code"}, {56'd0, scan_code}, 64'd0);
    check({tag, "_scan_err"}, {63'd0, scan_err}, 64'd0);
  endtask

  initial begin
    // make / break / extended
    add(8'h1C, 0, key(37));
    add(8'hF0, 0, key(37));
    add(8'h1C, 0, ALL);
    add(8'hE0, 0, ALL);
    add(8'h75, 0, key(51));
    add(8'hE0, 0, key(51));
    add(8'hF0, 0, key(51));
    add(8'h75, 0, ALL);
    add(8'h75, 0, ALL);
    // parity errors; an error drops a pending break prefix
    add(8'h1C, 1, ALL);
    add(8'hF0, 0, ALL);
    add(8'h1C, 1, ALL);
    add(8'h1C, 0, key(37));
    add(8'hF0, 0, key(37));
    add(8'h1C, 0, ALL);
    // overrun and pause
    add(8'h1C, 0, key(37));
    add(8'h29, 0, key(37) & key(54));
    add(8'hFF, 0, ALL);
    add(8'hE1, 0, ALL);
    add(8'h14, 0, ALL);
    add(8'h77, 0, ALL);
    add(8'hE1, 0, ALL);
    add(8'hF0, 0, ALL);
    add(8'h14, 0, ALL);
    add(8'hF0, 0, ALL);
    add(8'h77, 0, ALL);
    add(8'h1C, 0, key(37));
    add(8'h1C, 0, key(37));
    // ignored bytes keep prefixes
    add(8'hF0, 0, key(37));
    add(8'hAA, 0, key(37));
    add(8'h1C, 0, ALL);
    add(8'h29, 0, key(54));
    add(8'hE0, 0, key(54));
    add(8'h00, 0, ALL);
    add(8'h75, 0, ALL);
    add(8'hFA, 0, ALL);
    add(8'hEE, 0, ALL);
    // matrix corners
    add(8'h16, 0, key(0));
    add(8'h11, 0, key(0) & key(63));
    add(8'hF0, 0, key(0) & key(63));
    add(8'h16, 0, key(63));
    add(8'hF0, 0, key(63));
    add(8'h11, 0, ALL);
    add(8'h29, 0, key(54));

    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // A low pulse one sample short of the filter length must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk  = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].code, vecs[i].bad);
      repeat (4) @(negedge clk);
      check($sformatf("matrix_vec%0d_%h", i, vecs[i].code), kb_matrix, vecs[i].exp);
    end

    // Reset in the middle of a frame discards the partial byte
    send_bits(frame(8'h1C, 1'b0), 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("midframe_reset");
    rst = 1'b0;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    send_byte(8'h29, 0);
    repeat (4) @(negedge clk);
    check("after_reset_space", kb_matrix, key(54));

`ifdef PS2_TIMEOUT_EN
    begin
      logic [10:0] fr;
      int n;
      send_byte(8'hF0, 0);
      send_byte(8'h29, 0);
      repeat (4) @(negedge clk);
      check("release_space", kb_matrix, ALL);
      fr = frame(8'h29, 1'b0);
      send_bits(fr, 4);
      ps2_data = fr[4];
      repeat (HALF) @(negedge clk);
      expect_byte(8'h00, 1'b1);
      ps2_clk = 1'b0;
      n = 0;
      while (!scan_err && n < TO + 200) begin
        @(negedge clk);
        n++;
        if (n == HALF) ps2_clk = 1'b1;
      end
      check("timeout_latency", 64'(n), 64'(FL + 2 + TO));
      check("timeout_matrix", kb_matrix, ALL);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      send_byte(8'h29, 0);
      repeat (4) @(negedge clk);
      check("after_timeout_space", kb_matrix, key(54));
    end
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
